// File: rtl/noc_pkg.sv
// Shared NoC definitions: packet types, 32-bit router packet layout and the
// request record buffered ahead of the packetizer output stage.
package noc_pkg;

    typedef enum logic [1:0] {
        FILTER = 2'b00,
        IFMAP  = 2'b01,
        PSUM   = 2'b10,
        RSVD   = 2'b11
    } pkt_type_e;

    localparam int LAST_BIT = 31;
    localparam int TYPE_MSB = 30;
    localparam int TYPE_LSB = 29;
    localparam int DST_MSB  = 28;
    localparam int DST_LSB  = 21;
    localparam int DATA_MSB = 20;
    localparam int DATA_LSB = 13;
    localparam int SEQ_MSB  = 12;
    localparam int SEQ_LSB  = 0;
    localparam int SEQ_W    = 13;

    typedef struct packed {
        logic             last;
        pkt_type_e        ptype;
        logic [4:0]       dst_y;
        logic [2:0]       dst_x;
        logic [7:0]       data;
        logic [SEQ_W-1:0] seq;
    } noc_pkt_t;

    typedef struct packed {
        logic       last;
        pkt_type_e  ptype;
        logic [4:0] dst_y;
        logic [2:0] dst_x;
        logic [7:0] data;
    } noc_req_t;

    // Destination field is {dst_y, dst_x}, matching the router's decode.
    function automatic noc_pkt_t build_pkt(input noc_req_t r, input logic [SEQ_W-1:0] s);
        logic [31:0] p;
        p                   = '0;
        p[LAST_BIT]         = r.last;
        p[TYPE_MSB:TYPE_LSB] = r.ptype;
        p[DST_MSB:DST_LSB]  = {r.dst_y, r.dst_x};
        p[DATA_MSB:DATA_LSB] = r.data;
        p[SEQ_MSB:SEQ_LSB]  = s;
        return noc_pkt_t'(p);
    endfunction

endpackage

// File: rtl/noc_req_fifo.sv
// Synchronous request FIFO; pointers carry an extra wrap bit so full and
// empty are distinguished without a separate counter.
module noc_req_fifo #(
    parameter int DW    = 19,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DW-1:0]            wdata,
    input  logic                     pop,
    output logic [DW-1:0]            rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rptr[AW-1:0]];
    assign level = wptr - rptr;
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/noc_packetizer.sv
// NoC injection packetizer: legality check, request FIFO, per-type sequence
// tags and a one-entry valid/ready output register. NOC_PKTZ_STATS_EN adds counters.
module noc_packetizer
    import noc_pkg::*;
#(
    parameter int DEPTH_R    = 21,
    parameter int DEPTH_F    = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [1:0]                    in_type,
    input  logic [2:0]                    in_dst_x,
    input  logic [4:0]                    in_dst_y,
    input  logic [7:0]                    in_data,
    input  logic                          in_last,
    input  logic                          seq_clr,
    output logic                          pkt_valid,
    input  logic                          pkt_ready,
    output logic [31:0]                   pkt_data,
    output logic                          err_dst,
    input  logic                          err_clr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef NOC_PKTZ_STATS_EN
    ,
    output logic [15:0]                   stat_sent,
    output logic [7:0]                    stat_drop
`endif
);

    typedef enum logic {S_EMPTY, S_FULL} state_e;

    state_e           state;
    noc_req_t         req_in;
    noc_req_t         head;
    logic             legal;
    logic             accept;
    logic             full;
    logic             empty;
    logic             load;
    logic [SEQ_W-1:0] seq_f;
    logic [SEQ_W-1:0] seq_i;
    logic [SEQ_W-1:0] seq_p;
    logic [SEQ_W-1:0] cur_seq;
    logic [SEQ_W-1:0] load_seq;

    assign in_ready = !full;
    assign accept   = in_valid && in_ready;
    assign legal    = (in_type != 2'b11) && (int'(in_dst_x) < DEPTH_F)
                      && (int'(in_dst_y) < DEPTH_R);

    assign req_in = '{last: in_last, ptype: pkt_type_e'(in_type), dst_y: in_dst_y,
                      dst_x: in_dst_x, data: in_data};

    noc_req_fifo #(
        .DW    ($bits(noc_req_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept && legal),
        .wdata (req_in),
        .pop   (load),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    // Reload whenever the register is free or being drained this cycle.
    assign load = !empty && (state == S_EMPTY || pkt_ready);

    always_comb begin
        cur_seq = seq_f;
        case (head.ptype)
            IFMAP:   cur_seq = seq_i;
            PSUM:    cur_seq = seq_p;
            default: cur_seq = seq_f;
        endcase
    end

    assign load_seq = seq_clr ? '0 : cur_seq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_EMPTY;
            pkt_valid <= 1'b0;
            pkt_data  <= '0;
            seq_f     <= '0;
            seq_i     <= '0;
            seq_p     <= '0;
        end else begin
            if (seq_clr) begin
                seq_f <= '0;
                seq_i <= '0;
                seq_p <= '0;
            end
            // The loaded type's counter overrides the clear: it lands on 1.
            if (load) begin
                pkt_data <= build_pkt(head, load_seq);
                case (head.ptype)
                    IFMAP:   seq_i <= load_seq + SEQ_W'(1);
                    PSUM:    seq_p <= load_seq + SEQ_W'(1);
                    default: seq_f <= load_seq + SEQ_W'(1);
                endcase
            end
            case (state)
                S_EMPTY: if (load) begin
                    state     <= S_FULL;
                    pkt_valid <= 1'b1;
                end
                S_FULL: if (pkt_ready && empty) begin
                    state     <= S_EMPTY;
                    pkt_valid <= 1'b0;
                end
                default: begin
                    state     <= S_EMPTY;
                    pkt_valid <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                err_dst <= 1'b0;
        else if (accept && !legal) err_dst <= 1'b1;
        else if (err_clr)          err_dst <= 1'b0;
    end

`ifdef NOC_PKTZ_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_sent <= '0;
            stat_drop <= '0;
        end else begin
            if (pkt_valid && pkt_ready && stat_sent != 16'hFFFF)
                stat_sent <= stat_sent + 16'd1;
            if (accept && !legal && stat_drop != 8'hFF)
                stat_drop <= stat_drop + 8'd1;
        end
    end
`endif

endmodule
